aes_dec_key_sched_ctrl: RTL
===========================

// Module: aes_dec_key_sched_ctrl
// PURPOSE
//  Sequences the AES-128 inverse key-schedule step (aes_inv_key_shedualing) to feed the decryption
//  datapath with round keys in reverse order, from round NR down to round 0, one per handshake.
//  Holds the last-round key so that later blocks reuse it without a reload. Sits between the
//  key-load interface and the decrypt round pipeline. Supports one round key per cycle.
// PARAMETERS
//  NR         10     number of rounds; round-key count is NR+1 (AES-128 only, so 10)
//  RCON_INIT  8'h36  rcon used for the first inverse step (round NR -> NR-1)
// PORTS
//  clk         in   1    clock, rising edge
//  reset       in   1    asynchronous, active-high reset
//  start_i     in   1    start a round-key sequence; sampled only in IDLE
//  new_key_i   in   1    qualifies start_i: 1 = load key_i, 0 = reuse the stored key
//  key_i       in   128  last-round (round NR) key; byte n at [8n+7:8n], word w at [32w+31:32w]
//  abort_i     in   1    cancel the running sequence
//  rk_ready_i  in   1    consumer accepts rk_o this cycle
//  rk_v_o      out  1    rk_o/rk_round_o valid
//  rk_o        out  128  current round key
//  rk_round_o  out  4    round index of rk_o (NR..0)
//  busy_o      out  1    sequence in progress (state RUN)
//  done_o      out  1    one-cycle pulse after round-0 key is accepted
//  key_ok_o    out  1    a last-round key is stored (set on first load, cleared by reset only)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; rk_v_o=0, rk_o=0, rk_round_o=0, busy_o=0, done_o=0,
//   key_ok_o=0; stored key=0; rcon reg=0. A reset in mid-sequence drops it; there is no resume.
//  Registers: last_key (128), cur_key (128), cur_rcon (8), round (4), state (IDLE/RUN).
//  IDLE: start_i & new_key_i -> last_key<=key_i, cur_key<=key_i, key_ok_o<=1, go RUN.
//   start_i & ~new_key_i & key_ok_o -> cur_key<=last_key, go RUN.
//   start_i & ~new_key_i & ~key_ok_o -> ignored; stay IDLE.
//   On entering RUN: cur_rcon<=RCON_INIT, round<=NR.
//  Latency: start accepted at edge t -> rk_v_o=1 with the round-NR key in the cycle after t.
//  RUN: rk_v_o=1, rk_o=cur_key, rk_round_o=round. All three are registered, with no comb path
//   from inputs.
//   Transfer = rk_v_o & rk_ready_i. With no transfer, rk_o/rk_round_o hold stable.
//   Transfer & round!=0 -> cur_key<=key_next_o, cur_rcon<=key_rcon_o (inverse step on
//    cur_key/cur_rcon), round<=round-1. Back-to-back transfers give one key per cycle.
//   Transfer & round==0 -> go IDLE, rk_v_o<=0, done_o=1 for exactly one cycle.
//   rcon sequence: 36,1b,80,40,20,10,08,04,02,01. Never stepped past round 0.
//  abort_i in RUN (takes priority over a transfer in the same cycle) -> IDLE, rk_v_o<=0,
//   no done_o. last_key and key_ok_o are kept.
//  start_i in RUN is ignored; it is not queued. start_i and abort_i together in IDLE: start wins.
//  busy_o = (state==RUN). done_o and start_i can be high in the same cycle, and the start is
//   accepted then.
//  round is 4 bits wide and decrements only while nonzero, so it cannot wrap.
// TESTING
//  1 FIPS-197 key 000102..0f: load round-10 key 13111d7fe3944a17f307a78b4d2b30c5, ready=1 ->
//    11 keys on 11 consecutive cycles. Round 9 = 549932d1f08557681093ed9cbe2c974e,
//    round 0 = 000102030405060708090a0b0c0d0e0f, then one done_o pulse.
//  2 Random rk_ready_i backpressure (about 50%) -> same 11 keys in order, rk_o stable while
//    stalled, no skipped or duplicated round.
//  3 Second start with new_key_i=0 after test 1 -> identical 11-key sequence. Reuse start after
//    reset (key_ok_o=0) -> ignored, rk_v_o stays 0.
//  4 abort_i at round 5 together with rk_ready_i -> IDLE next cycle, no done_o. A later reuse
//    start restarts at round 10.
//  5 Assert reset asynchronously at round 3 -> all outputs 0 immediately, key_ok_o=0. start_i
//    during RUN and start_i in the done_o cycle -> checked per the rules above.

Source files
------------

// File: rtl/aes_dec_key_sched_ctrl.sv
// AES-128 decryption round-key sequencer: replays round keys NR..0 from a stored
// last-round key, one inverse key-schedule step per accepted handshake.

module aes_inv_key_shedualing (
  input  logic [127:0] key_i,
  input  logic [7:0]   rcon_i,
  output logic [127:0] key_next_o,
  output logic [7:0]   key_rcon_o
);

  // Forward S-box; entry 0 is the leftmost byte, so index with the inverted byte value.
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[~b];
  endfunction

  logic [31:0] n0, n1, n2, n3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot_w, sub_w;

  assign n0 = key_i[31:0];
  assign n1 = key_i[63:32];
  assign n2 = key_i[95:64];
  assign n3 = key_i[127:96];

  // Undo the forward recurrence w[i] = w[i-4] ^ f(w[i-1]) from the top word down.
  assign p3 = n3 ^ n2;
  assign p2 = n2 ^ n1;
  assign p1 = n1 ^ n0;

  // RotWord: byte order (b0,b1,b2,b3) -> (b1,b2,b3,b0), byte 0 in the low bits.
  assign rot_w = {p3[7:0], p3[31:8]};
  assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                  sbox(rot_w[15:8]),  sbox(rot_w[7:0])};
  assign p0    = n0 ^ sub_w ^ {24'd0, rcon_i};

  assign key_next_o = {p3, p2, p1, p0};

  // Previous rcon is this rcon divided by x in GF(2^8) modulo 0x11b.
  assign key_rcon_o = rcon_i[0] ? ((rcon_i >> 1) ^ 8'h8d) : (rcon_i >> 1);

endmodule

module aes_dec_key_sched_ctrl #(
  parameter int          NR        = 10,
  parameter logic [7:0]  RCON_INIT = 8'h36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start_i,
  input  logic         new_key_i,
  input  logic [127:0] key_i,
  input  logic         abort_i,
  input  logic         rk_ready_i,
  output logic         rk_v_o,
  output logic [127:0] rk_o,
  output logic [3:0]   rk_round_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         key_ok_o
);

  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_e;

  state_e       state_q;
  logic [127:0] last_key_q;
  logic [127:0] cur_key_q;
  logic [7:0]   cur_rcon_q;
  logic [3:0]   round_q;
  logic         rk_v_q;
  logic         done_q;
  logic         key_ok_q;

  logic [127:0] key_next_d;
  logic [7:0]   rcon_next_d;

  aes_inv_key_shedualing u_inv_step (
    .key_i      (cur_key_q),
    .rcon_i     (cur_rcon_q),
    .key_next_o (key_next_d),
    .key_rcon_o (rcon_next_d)
  );

  // NOTE: the key registers are ordinary flops, not a RAM, so they take the async reset
  // like everything else; a cleared stored key is part of the defined reset state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      last_key_q <= '0;
      cur_key_q  <= '0;
      cur_rcon_q <= '0;
      round_q    <= '0;
      rk_v_q     <= 1'b0;
      done_q     <= 1'b0;
      key_ok_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking default; a later assignment in this block overrides it, which
      // keeps done_q a single-cycle pulse without a separate clear path.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i && (new_key_i || key_ok_q)) begin
            if (new_key_i) begin
              last_key_q <= key_i;
              cur_key_q  <= key_i;
              key_ok_q   <= 1'b1;
            end else begin
              cur_key_q  <= last_key_q;
            end
            cur_rcon_q <= RCON_INIT;
            round_q    <= NR_L;
            rk_v_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            rk_v_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (rk_ready_i) begin
            if (round_q != 4'd0) begin
              cur_key_q  <= key_next_d;
              cur_rcon_q <= rcon_next_d;
              round_q    <= round_q - 4'd1;
            end else begin
              rk_v_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rk_v_o     = rk_v_q;
  assign rk_o       = cur_key_q;
  assign rk_round_o = round_q;
  assign busy_o     = (state_q == S_RUN);
  assign done_o     = done_q;
  assign key_ok_o   = key_ok_q;

endmodule
